// File: rtl/mem_arbiter.sv
// Single-port main-memory arbiter for icache refill, dcache refill and write-buffer drain.
// One outstanding transaction; fixed priority with a bounded write-burst counter and RAW blocking.
module mem_arbiter #(
  parameter int MAXWB = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [29:0] ic_adr,
  input  logic        ic_en,
  output logic        ic_done,
  input  logic [29:0] dc_adr,
  input  logic        dc_en,
  output logic        dc_done,
  input  logic [29:0] wb_adr,
  input  logic [31:0] wb_data,
  input  logic [3:0]  wb_byteen,
  input  logic        wb_en,
  output logic        wb_done,
  input  logic        wb_hit,
  output logic [31:0] rdata,
  output logic [29:0] memadr,
  output logic [31:0] memwdata,
  output logic [3:0]  membyteen,
  output logic        memrwb,
  output logic        memen,
  input  logic        memdone,
  input  logic [31:0] memrdata
);

  typedef enum logic [1:0] {IDLE, GRANT, RESP} state_t;
  typedef enum logic [1:0] {SEL_WB, SEL_DC, SEL_IC} sel_t;

  localparam logic [3:0] MAXWB_C = 4'(MAXWB);

  state_t      state_reg, state_next;
  sel_t        sel_reg, sel_next;
  logic [3:0]  wbcount_reg, wbcount_next;
  logic [29:0] memadr_reg, memadr_next;
  logic [31:0] memwdata_reg, memwdata_next;
  logic [3:0]  membyteen_reg, membyteen_next;
  logic        memrwb_reg, memrwb_next;
  logic        memen_reg, memen_next;
  logic [31:0] rdata_reg, rdata_next;
  logic [2:0]  done_reg, done_next;

  logic wb_elig, dc_elig, ic_elig, rd_elig;
  logic grant_wb, grant_dc, grant_ic;

  // A dcache read is held off while the write buffer still holds its word.
  always_comb begin
    wb_elig  = wb_en;
    dc_elig  = dc_en & ~wb_hit;
    ic_elig  = ic_en;
    rd_elig  = dc_elig | ic_elig;
    grant_wb = wb_elig & ((wbcount_reg < MAXWB_C) | ~rd_elig);
    grant_dc = ~grant_wb & dc_elig;
    grant_ic = ~grant_wb & ~dc_elig & ic_elig;
  end

  always_comb begin
    state_next     = state_reg;
    sel_next       = sel_reg;
    wbcount_next   = wbcount_reg;
    memadr_next    = memadr_reg;
    memwdata_next  = memwdata_reg;
    membyteen_next = membyteen_reg;
    memrwb_next    = memrwb_reg;
    memen_next     = memen_reg;
    rdata_next     = rdata_reg;
    done_next      = 3'b000;
    case (state_reg)
      IDLE: begin
        memen_next = 1'b0;
        if (grant_wb) begin
          memadr_next    = wb_adr;
          memwdata_next  = wb_data;
          membyteen_next = wb_byteen;
          memrwb_next    = 1'b0;
          memen_next     = 1'b1;
          sel_next       = SEL_WB;
          state_next     = GRANT;
          if (rd_elig && (wbcount_reg < MAXWB_C))
            wbcount_next = wbcount_reg + 4'd1;
        end else if (grant_dc || grant_ic) begin
          memadr_next    = grant_dc ? dc_adr : ic_adr;
          membyteen_next = 4'b1111;
          memrwb_next    = 1'b1;
          memen_next     = 1'b1;
          sel_next       = grant_dc ? SEL_DC : SEL_IC;
          state_next     = GRANT;
          wbcount_next   = 4'd0;
        end
      end
      GRANT: begin
        if (memdone) begin
          memen_next = 1'b0;
          if (memrwb_reg)
            rdata_next = memrdata;
          case (sel_reg)
            SEL_WB:  done_next = 3'b001;
            SEL_DC:  done_next = 3'b010;
            default: done_next = 3'b100;
          endcase
          state_next = RESP;
        end
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= IDLE;
      sel_reg       <= SEL_WB;
      wbcount_reg   <= 4'd0;
      memadr_reg    <= 30'd0;
      memwdata_reg  <= 32'd0;
      membyteen_reg <= 4'd0;
      memrwb_reg    <= 1'b1;
      memen_reg     <= 1'b0;
      rdata_reg     <= 32'd0;
      done_reg      <= 3'b000;
    end else begin
      state_reg     <= state_next;
      sel_reg       <= sel_next;
      wbcount_reg   <= wbcount_next;
      memadr_reg    <= memadr_next;
      memwdata_reg  <= memwdata_next;
      membyteen_reg <= membyteen_next;
      memrwb_reg    <= memrwb_next;
      memen_reg     <= memen_next;
      rdata_reg     <= rdata_next;
      done_reg      <= done_next;
    end
  end

  assign memadr    = memadr_reg;
  assign memwdata  = memwdata_reg;
  assign membyteen = membyteen_reg;
  assign memrwb    = memrwb_reg;
  assign memen     = memen_reg;
  assign rdata     = rdata_reg;
  assign wb_done   = done_reg[0];
  assign dc_done   = done_reg[1];
  assign ic_done   = done_reg[2];

endmodule
